// File: rtl/agp32_mem_ctrl_if.sv
// Backing-memory bus of the AGP32 memory controller: single outstanding
// request, one-cycle mem_ack completion with read data valid alongside.
interface agp32_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/agp32_mem_ctrl.sv
// AGP32 memory controller: instruction fetch through a one-entry line buffer,
// data read/write to backing memory, ack timeout and interrupt acknowledge.
module agp32_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        command,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  input  logic [3:0]        data_wstrb,
  input  logic              interrupt_req,
  output logic              mem_start_ready,
  output logic              ready,
  output logic              hit,
  output logic [1:0]        error,
  output logic              interrupt_ack,
  output logic [31:0]       inst_rdata,
  output logic [31:0]       inst_rdata_cache,
  output logic [31:0]       data_rdata,
  agp32_mem_ctrl_if.master  mem
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA} state_e;
  typedef enum logic [2:0] {
    CMD_NONE       = 3'd0,
    CMD_FETCH      = 3'd1,
    CMD_READ       = 3'd2,
    CMD_WRITE      = 3'd3,
    CMD_FETCH_READ = 3'd4
  } cmd_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [2:0]        cmd_q;
  logic [ADDR_W-1:0] inst_addr_q, data_addr_q, buf_tag;
  logic [31:0]       wdata_q, buf_word;
  logic [3:0]        wstrb_q;
  logic              buf_valid, gap_q, irq_done;
  logic [7:0]        wait_cnt;
  logic              accept, legal, fetch_cmd, lookup_hit, is_write;
  logic              req_live, timed_out, fetch_done, data_done, irq_fire;

  always_comb begin
    accept     = (state_q == S_IDLE) && (command != CMD_NONE);
    legal      = (command <= CMD_FETCH_READ);
    fetch_cmd  = (command == CMD_FETCH) || (command == CMD_FETCH_READ);
    lookup_hit = buf_valid && (buf_tag == inst_addr);
    is_write   = (cmd_q == CMD_WRITE);
    // gap_q keeps mem_req low for one cycle between the fetch and data phases
    req_live   = (state_q != S_IDLE) && !gap_q;
    timed_out  = req_live && !mem.mem_ack && (wait_cnt == WAIT_LAST);
    fetch_done = (state_q == S_FETCH) && mem.mem_ack;
    data_done  = (state_q == S_DATA) && req_live && mem.mem_ack;
    irq_fire   = (state_q == S_IDLE) && interrupt_req && !irq_done;

    state_d         = state_q;
    mem.mem_req     = req_live;
    mem.mem_we      = 1'b0;
    mem.mem_addr    = '0;
    mem.mem_wdata   = '0;
    mem.mem_wstrb   = '0;
    mem_start_ready = (state_q == S_IDLE);
    ready           = (state_q == S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (accept && legal) begin
          if (!fetch_cmd)                    state_d = S_DATA;
          else if (!lookup_hit)              state_d = S_FETCH;
          else if (command == CMD_FETCH_READ) state_d = S_DATA;
        end
      end
      S_FETCH: begin
        mem.mem_addr = inst_addr_q;
        if (mem.mem_ack)    state_d = (cmd_q == CMD_FETCH_READ) ? S_DATA : S_IDLE;
        else if (timed_out) state_d = S_IDLE;
      end
      S_DATA: begin
        if (req_live) begin
          mem.mem_addr  = data_addr_q;
          mem.mem_we    = is_write;
          mem.mem_wdata = is_write ? wdata_q : '0;
          mem.mem_wstrb = is_write ? wstrb_q : '0;
          if (mem.mem_ack || timed_out) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q            <= '0;
      inst_addr_q      <= '0;
      data_addr_q      <= '0;
      wdata_q          <= '0;
      wstrb_q          <= '0;
      buf_tag          <= '0;
      buf_word         <= '0;
      buf_valid        <= 1'b0;
      gap_q            <= 1'b0;
      wait_cnt         <= '0;
      hit              <= 1'b0;
      error            <= 2'b00;
      inst_rdata       <= '0;
      inst_rdata_cache <= '0;
      data_rdata       <= '0;
      interrupt_ack    <= 1'b0;
      irq_done         <= 1'b0;
    end else begin
      gap_q <= fetch_done && (cmd_q == CMD_FETCH_READ);

      if (state_q == S_IDLE || state_d != state_q) wait_cnt <= '0;
      else if (req_live)                           wait_cnt <= wait_cnt + 8'd1;

      if (accept) begin
        if (legal) begin
          cmd_q       <= command;
          inst_addr_q <= inst_addr;
          data_addr_q <= data_addr;
          wdata_q     <= data_wdata;
          wstrb_q     <= data_wstrb;
          error       <= 2'b00;
          if (fetch_cmd) begin
            hit <= lookup_hit;
            if (lookup_hit) inst_rdata_cache <= buf_word;
          end
        end else begin
          error <= 2'b11;
        end
      end

      if (fetch_done) begin
        inst_rdata <= mem.mem_rdata;
        buf_word   <= mem.mem_rdata;
        buf_tag    <= inst_addr_q;
        buf_valid  <= 1'b1;
      end

      if (data_done) begin
        if (!is_write)                                 data_rdata <= mem.mem_rdata;
        else if (buf_valid && buf_tag == data_addr_q) buf_valid  <= 1'b0;
      end

      if (timed_out) error <= 2'b01;

      interrupt_ack <= irq_fire;
      irq_done      <= interrupt_req && (irq_done || irq_fire);
    end
  end

endmodule

// File: tb/tb_agp32_mem_ctrl.sv
// Scoreboard bench for agp32_mem_ctrl: a line-buffer reference model predicts
// memory requests and completion results; monitors check them independently.
module tb_agp32_mem_ctrl;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  command = '0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
  logic [3:0]  data_wstrb = '0;
  logic        interrupt_req = 1'b0;
  logic        mem_start_ready, ready, hit, interrupt_ack;
  logic [1:0]  error;
  logic [31:0] inst_rdata, inst_rdata_cache, data_rdata;
  logic        resp_ack = 1'b0, late_ack = 1'b0;
  logic [31:0] resp_rdata = '0;

  agp32_mem_ctrl_if #(.ADDR_W(32)) mem_if ();
  assign mem_if.mem_ack   = resp_ack | late_ack;
  assign mem_if.mem_rdata = resp_rdata;

  agp32_mem_ctrl #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .command(command), .inst_addr(inst_addr),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .interrupt_req(interrupt_req), .mem_start_ready(mem_start_ready),
    .ready(ready), .hit(hit), .error(error), .interrupt_ack(interrupt_ack),
    .inst_rdata(inst_rdata), .inst_rdata_cache(inst_rdata_cache),
    .data_rdata(data_rdata), .mem(mem_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;    // ack in this request cycle; 0 = never ack
    logic [31:0] rdata;
    int          exp_len;  // expected request cycles; -1 = not checked
  } req_t;

  typedef struct packed {
    logic [1:0]  err;
    logic        hit;
    logic [31:0] inst;
    logic [31:0] cache;
    logic [31:0] data;
  } comp_t;

  req_t  req_q[$];
  comp_t comp_q[$];
  int    n_cmp = 0, n_fail = 0, irq_count = 0;

  // reference model: last-value outputs plus the single buffered line
  comp_t       m = '0;
  logic        bv = 1'b0;
  logic [31:0] bt = '0, bw = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_req(input logic [31:0] a, input logic we, input logic [31:0] wd,
                                   input logic [3:0] ws, input int d, input logic [31:0] r,
                                   input int len);
    req_t t;
    t.addr = a; t.we = we; t.wdata = wd; t.wstrb = ws;
    t.delay = d; t.rdata = r; t.exp_len = len;
    req_q.push_back(t);
  endfunction

  task automatic issue(input logic [2:0] c, input logic [31:0] ia, da, wd, input logic [3:0] ws);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!ready && n < 4000) begin @(posedge clk); #1; n++; end
    command = c; inst_addr = ia; data_addr = da; data_wdata = wd; data_wstrb = ws;
    @(posedge clk); #1;
    n = 0;
    // scramble inputs while busy: they must be ignored
    while (!ready && n < 4000) begin
      command    = 3'($urandom_range(1, 7));
      inst_addr  = $urandom;
      data_addr  = $urandom;
      data_wdata = $urandom;
      data_wstrb = 4'($urandom);
      @(posedge clk); #1;
      n++;
    end
    command = '0;
    if (n >= 4000) begin
      n_cmp++; n_fail++;
      $display("FAIL busy_bound: ready still 0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic do_cmd(input logic [2:0] c, input logic [31:0] ia, da, wd, input logic [3:0] ws,
                        input int d1, input logic [31:0] r1, input int d2, input logic [31:0] r2);
    bit ok;
    ok = 1'b1;
    if (c > 3'd4) m.err = 2'b11;
    else begin
      m.err = 2'b00;
      if (c == 3'd1 || c == 3'd4) begin
        if (bv && bt == ia) begin
          m.hit = 1'b1; m.cache = bw;
        end else begin
          m.hit = 1'b0;
          push_req(ia, 1'b0, '0, '0, d1, r1, (d1 == 0) ? TIMEOUT : d1);
          if (d1 == 0) begin m.err = 2'b01; ok = 1'b0; end
          else begin m.inst = r1; bw = r1; bt = ia; bv = 1'b1; end
        end
      end
      if (ok && c != 3'd1) begin
        push_req(da, c == 3'd3, wd, ws, d2, r2, (d2 == 0) ? TIMEOUT : d2);
        if (d2 == 0)       m.err = 2'b01;
        else if (c == 3'd3) begin if (bv && bt == da) bv = 1'b0; end
        else               m.data = r2;
      end
    end
    comp_q.push_back(m);
    issue(c, ia, da, wd, ws);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_start_ready"}, 32'(mem_start_ready), 32'd1);
    check({tag, "_hit"}, 32'(hit), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_irq_ack"}, 32'(interrupt_ack), 32'd0);
    check({tag, "_mem_req"}, 32'(mem_if.mem_req), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_if.mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_if.mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_if.mem_wdata, 32'd0);
    check({tag, "_mem_wstrb"}, 32'(mem_if.mem_wstrb), 32'd0);
    check({tag, "_inst_rdata"}, inst_rdata, 32'd0);
    check({tag, "_cache"}, inst_rdata_cache, 32'd0);
    check({tag, "_data_rdata"}, data_rdata, 32'd0);
  endtask

  // memory side: checks each request against the scoreboard and answers it
  initial begin : responder
    req_t cur;
    int   k;
    bit   in_req, acked;
    cur = '0; k = 0; in_req = 1'b0; acked = 1'b0;
    forever begin
      @(negedge clk);
      if (acked) check("req_drop_after_ack", 32'(mem_if.mem_req), 32'd0);
      acked = 1'b0; resp_ack = 1'b0; resp_rdata = $urandom;
      if (mem_if.mem_req) begin
        if (!in_req) begin
          in_req = 1'b1; k = 0;
          if (req_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_req: got request addr 0x%08h, required none", mem_if.mem_addr);
            cur = '0; cur.exp_len = -1;
          end else begin
            cur = req_q.pop_front();
            check("req_addr", mem_if.mem_addr, cur.addr);
            check("req_we", 32'(mem_if.mem_we), 32'(cur.we));
            if (cur.we) begin
              check("req_wdata", mem_if.mem_wdata, cur.wdata);
              check("req_wstrb", 32'(mem_if.mem_wstrb), 32'(cur.wstrb));
            end
          end
        end
        k++;
        if (k == cur.delay) begin resp_ack = 1'b1; resp_rdata = cur.rdata; acked = 1'b1; end
      end else if (in_req) begin
        in_req = 1'b0;
        if (cur.exp_len >= 0) check("req_len", 32'(k), 32'(cur.exp_len));
      end
    end
  end

  // processor side: compares results once the controller is idle again
  initial begin : comp_monitor
    comp_t e;
    bit    pending;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (pending && ready) begin
        pending = 1'b0;
        if (comp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_completion: got completion, required none");
        end else begin
          e = comp_q.pop_front();
          check("error", 32'(error), 32'(e.err));
          check("hit", 32'(hit), 32'(e.hit));
          check("inst_rdata", inst_rdata, e.inst);
          check("inst_rdata_cache", inst_rdata_cache, e.cache);
          check("data_rdata", data_rdata, e.data);
        end
      end
      if (ready && command != 3'd0 && rst_n) pending = 1'b1;
    end
  end

  initial begin : irq_monitor
    forever begin
      @(negedge clk);
      if (interrupt_ack) irq_count++;
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] pool [4];
    logic [2:0]  c;
    int          c0;
    pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200; pool[3] = 32'h400;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    do_cmd(3'd1, 32'h100, '0, '0, '0, 3, 32'hDEADBEEF, 0, '0);
    do_cmd(3'd1, 32'h100, '0, '0, '0, 1, '0, 0, '0);
    do_cmd(3'd3, '0, 32'h100, 32'hCAFEF00D, 4'hF, 0, '0, 2, '0);
    do_cmd(3'd1, 32'h100, '0, '0, '0, 2, 32'h12345678, 0, '0);
    do_cmd(3'd4, 32'h200, 32'h400, '0, '0, 2, 32'hA5A5A5A5, 4, 32'h5A5A0F0F);
    do_cmd(3'd2, '0, 32'h80, '0, '0, 0, '0, 0, '0);
    do_cmd(3'd2, '0, 32'h80, '0, '0, 0, '0, 1, 32'h0BADF00D);
    do_cmd(3'd6, 32'h100, 32'h100, '0, '0, 0, '0, 0, '0);
    do_cmd(3'd4, 32'h200, 32'h404, '0, '0, 1, '0, 3, 32'h77665544);
    do_cmd(3'd1, 32'h600, '0, '0, '0, TIMEOUT, 32'h13572468, 0, '0);
    do_cmd(3'd4, 32'h700, 32'h800, '0, '0, 0, '0, 2, '0);

    c0 = irq_count;
    interrupt_req = 1'b1;
    repeat (10) @(posedge clk);
    #1 interrupt_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("irq_held_10", 32'(irq_count - c0), 32'd1);
    c0 = irq_count;
    interrupt_req = 1'b1;
    do_cmd(3'd2, '0, 32'h40, '0, '0, 0, '0, 6, $urandom);
    repeat (4) @(posedge clk);
    #1 interrupt_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("irq_across_cmd", 32'(irq_count - c0), 32'd1);

    for (int i = 0; i < 40; i++) begin
      c = (i % 10 == 9) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(1, 4));
      do_cmd(c, pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)], $urandom,
             4'($urandom_range(1, 15)), $urandom_range(1, 5), $urandom,
             $urandom_range(1, 5), $urandom);
    end

    do_cmd(3'd1, 32'h300, '0, '0, '0, 2, 32'hFACE0001, 0, '0);
    push_req(32'h500, 1'b0, '0, '0, 0, '0, -1);
    m = '0; bv = 1'b0;
    comp_q.push_back(m);
    @(posedge clk); #1;
    command = 3'd1; inst_addr = 32'h500;
    @(posedge clk); #1;
    command = '0;
    repeat (3) @(posedge clk);
    #1 check("busy_before_reset", 32'(ready), 32'd0);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    late_ack = 1'b1;
    @(posedge clk);
    #1 late_ack = 1'b0;
    check("late_ack_ready", 32'(ready), 32'd1);
    check("late_ack_req", 32'(mem_if.mem_req), 32'd0);
    check("late_ack_inst", inst_rdata, 32'd0);
    do_cmd(3'd1, 32'h300, '0, '0, '0, 3, 32'hFACE0002, 0, '0);

    repeat (5) @(posedge clk);
    #1;
    check("req_queue_empty", 32'(req_q.size()), 32'd0);
    check("comp_queue_empty", 32'(comp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/agp32_mem_ctrl.md
AGP32_MEM_CTRL -- requirements
Module: agp32_mem_ctrl

Interface
REQ-001 Parameters (name, default, meaning): TIMEOUT, 255, max cycles waiting for mem_ack before abort; ADDR_W, 32, address width.
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1: sole clock; all state changes on rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- command, in, 3: processor request.
- inst_addr, in, 32: fetch address, word-aligned upstream.
- data_addr, in, 32: data address, word-aligned upstream.
- data_wdata, in, 32: store data.
- data_wstrb, in, 4: byte write strobes.
- interrupt_req, in, 1: processor interrupt request.
- mem_start_ready, out, 1: controller can accept a command.
- ready, out, 1: no operation in flight.
- hit, out, 1: last fetch served from line buffer.
- error, out, 2: status of last operation.
- interrupt_ack, out, 1: interrupt acknowledge pulse.
- inst_rdata, out, 32: fetched instruction, backing memory path.
- inst_rdata_cache, out, 32: fetched instruction, buffer path.
- data_rdata, out, 32: loaded data.
- mem_req, out, 1: backing memory request.
- mem_we, out, 1: backing memory write.
- mem_addr, out, 32: backing memory address.
- mem_wdata, out, 32: backing memory write data.
- mem_wstrb, out, 4: backing memory strobes.
- mem_ack, in, 1: backing memory completion, one cycle.
- mem_rdata, in, 32: backing memory read data, valid with mem_ack.

Function
REQ-003 Command encoding SHALL be: 0 none, 1 inst fetch, 2 data read, 3 data write, 4 inst fetch then data read; 5-7 illegal.
REQ-004 FSM states SHALL be IDLE, FETCH, DATA; mem_start_ready=1 and ready=1 exactly when in IDLE.
REQ-005 A command SHALL be accepted on an edge where state=IDLE and command!=0; command and addresses SHALL be registered at acceptance and held internally.
REQ-006 Accepting an illegal command SHALL set error=2'b11 and remain in IDLE.
REQ-007 A one-entry line buffer (tag, word, valid) SHALL exist; on accepting command 1 with valid and tag==inst_addr, inst_rdata_cache SHALL load the buffered word, hit SHALL be 1 the following cycle, and state SHALL remain IDLE (latency 1).
REQ-008 On a buffer miss for command 1 or 4, state SHALL go to FETCH, hit SHALL be 0, and mem_req=1, mem_we=0, mem_addr=inst_addr SHALL be driven from the next cycle until mem_ack is sampled.
REQ-009 On mem_ack in FETCH, inst_rdata and the buffer word SHALL capture mem_rdata, tag SHALL take the fetch address, valid SHALL be set, and the next state SHALL be DATA for command 4, otherwise IDLE.
REQ-010 Commands 2 and 3 SHALL go to DATA and drive mem_addr=data_addr; command 3 SHALL also drive mem_we=1, mem_wdata and mem_wstrb; mem_req SHALL be held until mem_ack is sampled.
REQ-011 On mem_ack in DATA, a read SHALL capture mem_rdata into data_rdata; a write whose address equals a valid buffer tag SHALL clear valid; the next state SHALL be IDLE.
REQ-012 mem_req SHALL be deasserted in the cycle after mem_ack; at most one request SHALL be outstanding.
REQ-013 An 8-bit wait counter SHALL clear on entering FETCH or DATA and increment each cycle without mem_ack; when it reaches TIMEOUT the FSM SHALL abort to IDLE, set error=2'b01, and leave the buffer unchanged.
REQ-014 error SHALL be 2'b00 after successful completion and SHALL hold its value until the next accepted command.
REQ-015 interrupt_ack SHALL be a one-cycle pulse issued on the first IDLE cycle in which interrupt_req=1 and no ack has been issued since interrupt_req last rose; it SHALL not repeat while interrupt_req stays high.
REQ-016 A command presented while not in IDLE SHALL be ignored.

Reset
REQ-017 While rst_n=0, the state SHALL be IDLE; mem_start_ready=1 and ready=1; hit, interrupt_ack, mem_req and mem_we SHALL be 0; error SHALL be 2'b00; all data, address and strobe outputs SHALL be 0; buffer valid SHALL be 0.
REQ-018 Reset asserted mid-operation SHALL abort at once with no buffer update; a mem_ack arriving after reset SHALL be ignored.

Verification
REQ-019 Fetch 0x100 with mem_ack after 3 cycles and mem_rdata=0xDEADBEEF -> inst_rdata=0xDEADBEEF, hit=0, ready returns to 1; refetch 0x100 -> hit=1, inst_rdata_cache=0xDEADBEEF one cycle later, mem_req stays 0.
REQ-020 Write to 0x100 with wstrb=4'hF, then fetch 0x100 -> second access misses, mem_req=1.
REQ-021 Command 4 with inst_addr=0x200 and data_addr=0x400 -> two sequential requests (0x200 then 0x400), data_rdata captured, ready=1 only after the second mem_ack.
REQ-022 Data read with no mem_ack -> after 255 cycles error=2'b01 and state IDLE; next successful read -> error=2'b00.
REQ-023 command=6 -> error=2'b11, mem_req stays 0; interrupt_req held high 10 cycles -> exactly one interrupt_ack pulse.
REQ-024 rst_n pulsed low during FETCH -> all outputs at reset values, buffer invalid, late mem_ack has no effect.
